// File: rtl/digit_scan_ctrl_if.sv
// Bundle of the load handshake and display-side signals of digit_scan_ctrl.
//   master : upstream/test side; drives en, load_valid, load_data and
//            observes load_ready plus the scan outputs.
//   slave  : the scan sequencer itself.
// Signals:
//   en          scan advance enable
//   load_valid  new 4-digit word offered
//   load_data   digit 0 in [W-1:0] .. digit 3 in [4W-1:3W]
//   load_ready  sequencer can accept load_data this cycle
//   sel_a/sel_b digit index MSB/LSB towards the 2-to-4 decoder
//   digit       value of the currently selected digit
//   blank       display must be dark this cycle
//   frame_done  one-cycle pulse after the digit 3 slot ends
interface digit_scan_ctrl_if #(
  parameter int unsigned W = 4
);
  logic           en;
  logic           load_valid;
  logic [4*W-1:0] load_data;
  logic           load_ready;
  logic           sel_a;
  logic           sel_b;
  logic [W-1:0]   digit;
  logic           blank;
  logic           frame_done;

  modport master (
    output en,
    output load_valid,
    output load_data,
    input  load_ready,
    input  sel_a,
    input  sel_b,
    input  digit,
    input  blank,
    input  frame_done
  );

  modport slave (
    input  en,
    input  load_valid,
    input  load_data,
    output load_ready,
    output sel_a,
    output sel_b,
    output digit,
    output blank,
    output frame_done
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed scan sequencer for a 4-digit display. Rotates a 2-bit
// digit index (driving the A/B inputs of the 2-to-4 digit decoder) and
// presents the matching digit nibble. New 4-digit words are double-buffered
// and swapped in only at frame boundaries so a frame never mixes values.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  digit_scan_ctrl_if slave modport (load handshake + scan outputs)
// Parameters:
//   DIV  clock cycles per digit slot (>= 2)
//   W    width of one digit value
module digit_scan_ctrl #(
  parameter int unsigned DIV = 4,
  parameter int unsigned W   = 4
) (
  input logic               clk,
  input logic               rst,
  digit_scan_ctrl_if.slave  bus
);

  localparam int unsigned CntW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  // A one-cycle slot would leave no lit time after the blanking gap.
  if (DIV < 2) begin : gen_div_check
    $error("digit_scan_ctrl: DIV must be at least 2");
  end

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [4*W-1:0]  active_q, active_d;
  logic [4*W-1:0]  shadow_q, shadow_d;
  logic            pend_q, pend_d;
  logic            disp_valid_q, disp_valid_d;
  logic            frame_done_q, frame_done_d;

  logic advance;
  logic slot_end;
  logic wrap;
  logic load_fire;

  always_comb begin
    advance   = bus.en && disp_valid_q;
    slot_end  = (cnt_q == CntMax);
    wrap      = advance && slot_end && (idx_q == 2'd3);
    load_fire = bus.load_valid && !pend_q;
  end

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    disp_valid_d = disp_valid_q;
    frame_done_d = wrap;

    if (advance) begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;  // 3 -> 0 wraps naturally
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    // Swap in the buffered word together with the return to digit 0.
    if (wrap && pend_q) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end

    // load_fire implies pend_q == 0, so it never collides with the swap
    // above; a load landing on the wrap cycle waits for the next frame.
    if (load_fire) begin
      if (!disp_valid_q) begin
        active_d     = bus.load_data;
        disp_valid_d = 1'b1;
        cnt_d        = '0;
        idx_d        = 2'd0;
      end else begin
        shadow_d = bus.load_data;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      active_q     <= '0;
      shadow_q     <= '0;
      pend_q       <= 1'b0;
      disp_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      disp_valid_q <= disp_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Outputs depend on registered state only.
  logic [W-1:0] digit_mux;

  always_comb begin
    digit_mux = '0;
    unique case (idx_q)
      2'd0: digit_mux = active_q[0*W +: W];
      2'd1: digit_mux = active_q[1*W +: W];
      2'd2: digit_mux = active_q[2*W +: W];
      2'd3: digit_mux = active_q[3*W +: W];
      default: digit_mux = '0;
    endcase
  end

  assign bus.load_ready = ~pend_q;
  assign bus.sel_a      = idx_q[1];
  assign bus.sel_b      = idx_q[0];
  assign bus.digit      = digit_mux;
  // Dark before the first load and for the first cycle of every slot.
  assign bus.blank      = ~disp_valid_q | (cnt_q == '0);
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
module tb_digit_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  digit_scan_ctrl_if #(.W(4)) bus ();

  digit_scan_ctrl #(
    .DIV (4),
    .W   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int          p = 0;          // model position in frame: idx*4 + cnt
  bit          started = 1'b0; // model of disp_valid
  logic [15:0] exp_active = 16'h0;

  // Expected {sel_a, sel_b, digit, blank} at frame position pp.
  function automatic logic [6:0] exp_disp(int pp);
    logic [1:0] s;
    logic [3:0] d;
    logic       b;
    s = 2'(pp / 4);
    d = exp_active[(pp / 4) * 4 +: 4];
    b = !started || ((pp % 4) == 0);
    return {s, d, b};
  endfunction

  function automatic logic [6:0] act_disp();
    return {bus.sel_a, bus.sel_b, bus.digit, bus.blank};
  endfunction

  task automatic step();
    bit adv;
    adv = bus.en && started && !rst;
    @(posedge clk);
    #1;
    if (adv) p = (p + 1) % 16;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 16'h9999;
    step();
    step();
    checks++;
    if ({bus.sel_a, bus.sel_b, bus.digit, bus.blank} !== 7'b00_0000_1) begin
      errors++;
      $display("FAIL reset_disp got %b exp %b", act_disp(), 7'b00_0000_1);
    end
    checks++;
    if (bus.load_ready !== 1'b1 || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b fd=%b exp ready=1 fd=0",
               bus.load_ready, bus.frame_done);
    end
    rst = 1'b0;
    bus.load_valid = 1'b0;
    step();
    checks++;
    if (bus.digit !== 4'h0 || bus.blank !== 1'b1) begin
      errors++;
      $display("FAIL reset_noload got digit=%h blank=%b exp digit=0 blank=1",
               bus.digit, bus.blank);
    end
  endtask

  task automatic test_first_load();
    bus.load_data = 16'h4321;
    bus.load_valid = 1'b1;
    step();
    bus.load_valid = 1'b0;
    exp_active = 16'h4321;
    started = 1'b1;
    p = 0;
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (act_disp() !== exp_disp(p) || bus.frame_done !== 1'b0 || bus.load_ready !== 1'b1) begin
        errors++;
        $display("FAIL first_load p=%0d got disp=%b fd=%b ready=%b exp disp=%b fd=0 ready=1",
                 p, act_disp(), bus.frame_done, bus.load_ready, exp_disp(p));
      end
      step();
    end
    checks++;
    if (bus.frame_done !== 1'b1 || act_disp() !== 7'b00_0001_1) begin
      errors++;
      $display("FAIL first_frame_done got fd=%b disp=%b exp fd=1 disp=%b",
               bus.frame_done, act_disp(), 7'b00_0001_1);
    end
    step();
    checks++;
    if (bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_pulse got %b exp 0", bus.frame_done);
    end
  endtask

  task automatic test_mid_frame_load();
    while (p != 5) step();
    bus.load_data = 16'hABCD;
    bus.load_valid = 1'b1;
    step();
    bus.load_valid = 1'b0;
    while (p != 0) begin
      checks++;
      if (act_disp() !== exp_disp(p) || bus.load_ready !== 1'b0) begin
        errors++;
        $display("FAIL mid_load_hold p=%0d got disp=%b ready=%b exp disp=%b ready=0",
                 p, act_disp(), bus.load_ready, exp_disp(p));
      end
      step();
    end
    exp_active = 16'hABCD;
    checks++;
    if (act_disp() !== 7'b00_1101_1 || bus.load_ready !== 1'b1 || bus.frame_done !== 1'b1) begin
      errors++;
      $display("FAIL mid_load_apply got disp=%b ready=%b fd=%b exp disp=%b ready=1 fd=1",
               act_disp(), bus.load_ready, bus.frame_done, 7'b00_1101_1);
    end
  endtask

  task automatic test_back_to_back();
    bus.load_data = 16'h1234;
    bus.load_valid = 1'b1;
    step();
    bus.load_data = 16'h5555;
    while (p != 0) begin
      checks++;
      if (act_disp() !== exp_disp(p) || bus.load_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_wait p=%0d got disp=%b ready=%b exp disp=%b ready=0",
                 p, act_disp(), bus.load_ready, exp_disp(p));
      end
      step();
    end
    exp_active = 16'h1234;
    checks++;
    if (act_disp() !== exp_disp(0) || bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_apply1 got disp=%b ready=%b exp disp=%b ready=1",
               act_disp(), bus.load_ready, exp_disp(0));
    end
    step();
    bus.load_valid = 1'b0;
    while (p != 0) begin
      checks++;
      if (act_disp() !== exp_disp(p) || bus.load_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_second p=%0d got disp=%b ready=%b exp disp=%b ready=0",
                 p, act_disp(), bus.load_ready, exp_disp(p));
      end
      step();
    end
    exp_active = 16'h5555;
    do begin
      checks++;
      if (act_disp() !== exp_disp(p) || bus.load_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_apply2 p=%0d got disp=%b ready=%b exp disp=%b ready=1",
                 p, act_disp(), bus.load_ready, exp_disp(p));
      end
      step();
    end while (p != 0);
    checks++;
    if (bus.frame_done !== 1'b1 || bus.digit !== 4'h5) begin
      errors++;
      $display("FAIL b2b_nodup got fd=%b digit=%h exp fd=1 digit=5", bus.frame_done, bus.digit);
    end
  endtask

  task automatic test_enable();
    while (p != 6) step();
    bus.en = 1'b0;
    repeat (10) begin
      step();
      checks++;
      if (act_disp() !== exp_disp(6) || bus.frame_done !== 1'b0) begin
        errors++;
        $display("FAIL en_freeze got disp=%b fd=%b exp disp=%b fd=0",
                 act_disp(), bus.frame_done, exp_disp(6));
      end
    end
    bus.en = 1'b1;
    step();
    checks++;
    if (p != 7 || act_disp() !== 7'b01_0101_0) begin
      errors++;
      $display("FAIL en_resume1 got disp=%b exp %b", act_disp(), 7'b01_0101_0);
    end
    step();
    checks++;
    if (act_disp() !== 7'b10_0101_1) begin
      errors++;
      $display("FAIL en_resume2 got disp=%b exp %b", act_disp(), 7'b10_0101_1);
    end
    while (p != 15) step();
    bus.en = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if (bus.frame_done !== 1'b0 || act_disp() !== exp_disp(15)) begin
        errors++;
        $display("FAIL en_wrap_hold got fd=%b disp=%b exp fd=0 disp=%b",
                 bus.frame_done, act_disp(), exp_disp(15));
      end
    end
    bus.en = 1'b1;
    step();
    checks++;
    if (bus.frame_done !== 1'b1 || act_disp() !== exp_disp(0)) begin
      errors++;
      $display("FAIL en_wrap_resume got fd=%b disp=%b exp fd=1 disp=%b",
               bus.frame_done, act_disp(), exp_disp(0));
    end
  endtask

  task automatic test_reset_mid();
    while (p != 3) step();
    bus.load_data = 16'hFEDC;
    bus.load_valid = 1'b1;
    step();
    bus.load_valid = 1'b0;
    checks++;
    if (bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pend got ready=%b exp 0", bus.load_ready);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    started = 1'b0;
    p = 0;
    checks++;
    if ({bus.sel_a, bus.sel_b, bus.digit, bus.blank, bus.load_ready, bus.frame_done}
        !== 9'b00_0000_1_1_0) begin
      errors++;
      $display("FAIL rst_mid_state got %b exp %b",
               {bus.sel_a, bus.sel_b, bus.digit, bus.blank, bus.load_ready, bus.frame_done},
               9'b00_0000_1_1_0);
    end
    repeat (5) begin
      step();
      checks++;
      if (act_disp() !== 7'b00_0000_1) begin
        errors++;
        $display("FAIL rst_mid_idle got disp=%b exp %b", act_disp(), 7'b00_0000_1);
      end
    end
    bus.load_data = 16'h0007;
    bus.load_valid = 1'b1;
    step();
    bus.load_valid = 1'b0;
    started = 1'b1;
    p = 0;
    exp_active = 16'h0007;
    do begin
      checks++;
      if (act_disp() !== exp_disp(p) || bus.load_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_reload p=%0d got disp=%b ready=%b exp disp=%b ready=1",
                 p, act_disp(), bus.load_ready, exp_disp(p));
      end
      step();
    end while (p != 0);
    checks++;
    if (bus.frame_done !== 1'b1 || bus.digit !== 4'h7) begin
      errors++;
      $display("FAIL rst_mid_discard got fd=%b digit=%h exp fd=1 digit=7",
               bus.frame_done, bus.digit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data = '0;
    test_reset();
    test_first_load();
    test_mid_frame_load();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
